// File: rtl/filter_out_requant.sv
// FIR output post-processing: warm-up discard, decimation by DEC, round/saturate to OUT_W, show-ahead output FIFO.
// Optional REQUANT_STATS_EN adds sat_cnt, a saturating count of clipped kept samples.
module filter_out_requant #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 12,
  parameter int SHIFT      = 12,
  parameter int DEC        = 4,
  parameter int SKIP       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_W-1:0]        data_in,
  input  logic                          in_en,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef REQUANT_STATS_EN
  ,
  output logic [15:0]                   sat_cnt
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RW  = IN_W + 1;
  localparam int DCW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int SCW = (SKIP > 1) ? $clog2(SKIP) : 1;

  localparam logic signed [RW-1:0] HALF    = RW'(2 ** (SHIFT - 1));
  localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  // One guard bit keeps x + 2^(SHIFT-1) from wrapping at the positive limit.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [RW-1:0] s;
    s = $signed({x[IN_W-1], x}) + HALF;
    return s >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RW-1:0] r);
    if (r > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (r < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  typedef enum logic {WARMUP, RUN} state_e;

  state_e                   state_q, state_d;
  logic [SCW-1:0]           skip_q, skip_d;
  logic [DCW-1:0]           dec_q, dec_d;
  logic                     keep_p0;
  logic signed [RW-1:0]     rnd_p0;

  logic                     vld_p1_q;
  logic signed [OUT_W-1:0]  data_p1_q;

  logic [AW:0]              wr_ptr_q, wr_ptr_d;
  logic [AW:0]              rd_ptr_q, rd_ptr_d;
  logic                     overflow_q, overflow_d;
  logic signed [OUT_W-1:0]  mem_q [FIFO_DEPTH];
  logic                     empty, full, push, pop;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    dec_d   = dec_q;
    keep_p0 = 1'b0;
    case (state_q)
      WARMUP: begin
        if (SKIP == 0) begin
          state_d = RUN;
        end else if (in_en) begin
          if (skip_q == SCW'(SKIP - 1)) state_d = RUN;
          else                          skip_d  = skip_q + 1'b1;
        end
      end
      RUN: begin
        if (in_en) begin
          keep_p0 = (dec_q == '0);
          dec_d   = (dec_q == DCW'(DEC - 1)) ? '0 : dec_q + 1'b1;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  assign rnd_p0 = round_shift(data_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WARMUP;
      skip_q   <= '0;
      dec_q    <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      dec_q    <= dec_d;
      vld_p1_q <= keep_p0;
    end
  end

  // ---- stage p0 -> p1: rounded/saturated sample register
  always_ff @(posedge clk) begin
    if (keep_p0) data_p1_q <= saturate(rnd_p0);
  end

  // ---- stage p1 -> FIFO
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = out_valid & out_ready;
  assign push  = vld_p1_q & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (vld_p1_q && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_p1_q;
  end

  assign out_valid  = ~empty;
  assign out_data   = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;

`ifdef REQUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        clip_p0;

  assign clip_p0 = keep_p0 && ((rnd_p0 > SAT_MAX) || (rnd_p0 < SAT_MIN));

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clip_p0 && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_cnt_q <= '0;
    else      sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_filter_out_requant.sv
// Bench for filter_out_requant: three configurations driven in parallel and checked every cycle
// against a queue-based reference model, plus directed checks of the documented scenarios.
module tb_filter_out_requant;

  localparam int DEPTH = 8;
  localparam int SHIFT = 12;
  localparam int P_SKIP [3] = '{16, 0, 0};
  localparam int P_DEC  [3] = '{1, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] x;
  logic        en, rdy;
  logic [11:0] od [3];
  logic        ov [3];
  logic [3:0]  lv [3];
  logic        of [3];
`ifdef REQUANT_STATS_EN
  logic [15:0] sc [3];
`endif

  always #10 clk = ~clk;

  filter_out_requant #(.IN_W(24), .OUT_W(12), .SHIFT(12), .DEC(1), .SKIP(16), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .data_in(x), .in_en(en), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(rdy), .fifo_level(lv[0]), .overflow(of[0])
`ifdef REQUANT_STATS_EN
    , .sat_cnt(sc[0])
`endif
  );

  filter_out_requant #(.IN_W(24), .OUT_W(12), .SHIFT(12), .DEC(1), .SKIP(0), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .data_in(x), .in_en(en), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(rdy), .fifo_level(lv[1]), .overflow(of[1])
`ifdef REQUANT_STATS_EN
    , .sat_cnt(sc[1])
`endif
  );

  filter_out_requant #(.IN_W(24), .OUT_W(12), .SHIFT(12), .DEC(4), .SKIP(0), .FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst(rst), .data_in(x), .in_en(en), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(rdy), .fifo_level(lv[2]), .overflow(of[2])
`ifdef REQUANT_STATS_EN
    , .sat_cnt(sc[2])
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state, one slot per instance
  int m_acc  [3];
  int m_cnt  [3];
  int m_fifo [3][DEPTH];
  int m_stg  [3];
  bit m_stgv [3];
  bit m_ovf  [3];
  int m_sat  [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int requant(input logic [23:0] v, output bit clip);
    int xs, r;
    xs   = $signed(v);
    r    = (xs + (1 << (SHIFT - 1))) >>> SHIFT;
    clip = 1'b0;
    if (r > 2047)       begin r = 2047;  clip = 1'b1; end
    else if (r < -2048) begin r = -2048; clip = 1'b1; end
    return r & 12'hFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_stg[i] = 0; m_stgv[i] = 1'b0; m_ovf[i] = 1'b0; m_sat[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit pop, keep, clip;
      int old;
      old = m_cnt[i];
      pop = (old > 0) && rdy;
      if (pop) begin
        for (int k = 0; k < DEPTH - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
        m_cnt[i]--;
      end
      if (m_stgv[i]) begin
        if (old < DEPTH || pop) begin
          m_fifo[i][m_cnt[i]] = m_stg[i];
          m_cnt[i]++;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
      keep = en && (m_acc[i] >= P_SKIP[i]) && (((m_acc[i] - P_SKIP[i]) % P_DEC[i]) == 0);
      if (en) m_acc[i]++;
      m_stgv[i] = keep;
      if (keep) begin
        m_stg[i] = requant(x, clip);
        if (clip && m_sat[i] < 65535) m_sat[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid[%0d]", i), 32'(ov[i]), 32'(m_cnt[i] > 0));
      check($sformatf("data[%0d]", i), 32'(od[i]), (m_cnt[i] > 0) ? m_fifo[i][0] : 0);
      check($sformatf("level[%0d]", i), 32'(lv[i]), m_cnt[i]);
      check($sformatf("ovf[%0d]", i), 32'(of[i]), 32'(m_ovf[i]));
`ifdef REQUANT_STATS_EN
      check($sformatf("satcnt[%0d]", i), 32'(sc[i]), m_sat[i]);
`endif
    end
  endtask

  // drive away from the edge, let the model and DUT take the edge, compare 1 ns later
  task automatic cycle(input logic [23:0] xv, input bit e, input bit r);
    x = xv; en = e; rdy = r;
    @(posedge clk);
    model_step();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; rdy = 1'b0;
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    #2 rst = 1'b1;
    cycle(24'h0, 1'b0, 1'b0);
  endtask

  logic [23:0] t2_in  [4];
  int          t2_exp [4];
  int          obs_val [8];
  int          obs_cyc [8];
  int          n_obs;

  initial begin
    rst = 1'b1; x = '0; en = 1'b0; rdy = 1'b0;
    t2_in  = '{24'h7FFFFF, 24'hFFFFFF, 24'h800000, 24'h000800};
    t2_exp = '{'h7FF, 'h000, 'h800, 'h001};
    @(negedge clk);
    do_reset();

    // warm-up discard then 0x001800 -> 2 after two clocks
    for (int k = 0; k < 16; k++) cycle(24'h0, 1'b1, 1'b1);
    check("t1_warm_level", 32'(lv[0]), 0);
    cycle(24'h001800, 1'b1, 1'b1);
    check("t1_not_yet", 32'(ov[0]), 0);
    cycle(24'h0, 1'b0, 1'b1);
    check("t1_valid", 32'(ov[0]), 1);
    check("t1_data", 32'(od[0]), 'h002);

    // rounding and saturation corners
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 4) cycle(t2_in[j], 1'b1, 1'b1);
      else       cycle(24'h0, 1'b0, 1'b1);
      if (j >= 1) check($sformatf("t2_data%0d", j - 1), 32'(od[1]), t2_exp[j-1]);
    end
`ifdef REQUANT_STATS_EN
    check("t2_satcnt", 32'(sc[1]), 1);
`endif

    // decimation by 4 of a ramp
    do_reset();
    n_obs = 0;
    for (int n = 0; n < 19; n++) begin
      if (n < 16) cycle(24'(n << 12), 1'b1, 1'b1);
      else        cycle(24'h0, 1'b0, 1'b1);
      if (ov[2] && n_obs < 8) begin
        obs_val[n_obs] = od[2];
        obs_cyc[n_obs] = n;
        n_obs++;
      end
    end
    check("t3_count", n_obs, 4);
    for (int j = 0; j < 4 && j < n_obs; j++) begin
      check($sformatf("t3_val%0d", j), obs_val[j], 4 * j);
      check($sformatf("t3_cyc%0d", j), obs_cyc[j], 4 * j + 1);
    end

    // back-pressure: fill, drop two, drain in order
    do_reset();
    for (int k = 0; k < 16; k++) cycle(24'h0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(24'((k + 1) << 12), 1'b1, 1'b0);
    cycle(24'h0, 1'b0, 1'b0);
    check("t4_level_full", 32'(lv[0]), 8);
    check("t4_overflow", 32'(of[0]), 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_drain%0d", k), 32'(od[0]), k + 1);
      cycle(24'h0, 1'b0, 1'b1);
    end
    check("t4_empty", 32'(lv[0]), 0);
    check("t4_ovf_sticky", 32'(of[0]), 1);

    // push and pop together at full
    do_reset();
    for (int k = 0; k < 16; k++) cycle(24'h0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) begin
      cycle(24'($urandom_range(0, 24'h7FFFFF)), 1'b1, k >= 9);
      if (k >= 8) check($sformatf("t5_level%0d", k), 32'(lv[0]), 8);
    end
    check("t5_no_ovf", 32'(of[0]), 0);

    // mid-stream async reset, then warm-up restarts
    do_reset();
    for (int k = 0; k < 16; k++) cycle(24'h00A000, 1'b1, 1'b1);
    check("t6_warm_level", 32'(lv[0]), 0);
    check("t6_warm_valid", 32'(ov[0]), 0);
    cycle(24'h00A000, 1'b1, 1'b1);
    cycle(24'h0, 1'b0, 1'b0);
    check("t6_first", 32'(od[0]), 'h00A);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [23:0] v;
      v = 24'($urandom);
      if ($urandom_range(0, 3) == 0) v = 24'($signed(12'($urandom)));
      cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if (k == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
